// File: rtl/seq_dot_prod.sv
// rtl/seq_dot_prod.sv - streaming LANES-wide dot product, optional SEQ_DOT_PROD_SAT_EN saturating accumulator
module seq_dot_prod #(
    parameter int N     = 32,
    parameter int LEN   = 16,
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] inarray1 [LANES-1:0],
    input  logic [N-1:0] inarray2 [LANES-1:0],
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] dotprodout
);

    localparam int BEATS = LEN / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  dot_q, dot_d;
    logic [N-1:0]  final_n;
    logic          last_beat;

    assign last_beat = (cnt_q == CW'(BEATS - 1));

`ifdef SEQ_DOT_PROD_SAT_EN
    localparam int AW = 2 * N + $clog2(LEN);
    localparam logic signed [AW-1:0] SAT_MAX = AW'({1'b0, {(N-1){1'b1}}});
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    logic        [2*N-1:0] prod [LANES];
    logic signed [AW-1:0]  lane_sum, acc_q, acc_d, total;

    // Full-width signed lane products summed into the wide accumulator domain
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            prod[i]  = {{N{inarray1[i][N-1]}}, inarray1[i]} * {{N{inarray2[i][N-1]}}, inarray2[i]};
            lane_sum = lane_sum + AW'(signed'(prod[i]));
        end
    end

    assign total = acc_q + lane_sum;

    // Clamp the completed vector sum into the signed N-bit result range
    always_comb begin
        if (total > SAT_MAX) begin
            final_n = SAT_MAX[N-1:0];
        end else if (total < SAT_MIN) begin
            final_n = SAT_MIN[N-1:0];
        end else begin
            final_n = total[N-1:0];
        end
    end
`else
    logic [N-1:0] prod [LANES];
    logic [N-1:0] lane_sum, acc_q, acc_d, total;

    // Lane products and their sum wrap modulo 2^N, like the legacy adder tree
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            prod[i]  = inarray1[i] * inarray2[i];
            lane_sum = lane_sum + prod[i];
        end
    end

    assign total   = acc_q + lane_sum;
    assign final_n = total;
`endif

    // Handshake FSM: accumulate beats in ACCUM, present the result in HOLD
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        dot_d     = dot_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (last_beat) begin
                        dot_d   = final_n;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        acc_d = total;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State registers; reset discards any partial sum and the last result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            dot_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dot_q   <= dot_d;
        end
    end

    assign dotprodout = dot_q;

endmodule

// File: doc/seq_dot_prod.md
Name: seq_dot_prod

Overview:
- Streaming, parametrised successor to the combinational dot-product block.
- Accepts LANES element pairs per beat over a valid/ready input handshake and multiplies them in LANES parallel lanes.
- Accumulates over LEN/LANES beats and presents one N-bit dot product per vector on a valid/ready output handshake.
- Sits between the operand buffers and the result writeback of the matrix multiplier array; one instance per output element.

Parameters:
- N, 32, element and result width (two's-complement signed).
- LEN, 16, vector length in elements; must be a multiple of LANES.
- LANES, 4, element pairs consumed per beat (parallel multipliers); 1 <= LANES <= LEN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- inarray1  in  N x LANES  operand A lanes, unpacked [LANES-1:0].
- inarray2  in  N x LANES  operand B lanes, unpacked [LANES-1:0].
- out_valid  out  1  dotprodout holds a completed result.
- out_ready  in  1  downstream accepts the result.
- dotprodout  out  N  dot product of the last completed vector.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, dotprodout=0, accumulator=0, beat counter=0, state=ACCUM.
- Beat handshake: a beat transfers on a rising edge where in_valid && in_ready. Operands are sampled only at a transfer; inputs are ignored at all other times.
- Lane arithmetic: product_i = inarray1[i]*inarray2[i], signed.
  - The lane sum is the sum of all LANES products, formed combinationally in the transfer cycle.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On a transfer that is not the last beat: accumulator += lane sum, and the beat counter increments.
  - On the last beat (counter == LEN/LANES-1): dotprodout <= accumulator + lane sum, accumulator <= 0, counter <= 0, next state HOLD.
- State HOLD:
  - in_ready=0, out_valid=1, dotprodout stable.
  - On out_ready=1: out_valid <= 0, next state ACCUM. in_ready is 1 in the following cycle.
  - dotprodout keeps its last value after the handshake.
- Latency and throughput:
  - out_valid rises the cycle after the last-beat transfer.
  - Minimum vector period is LEN/LANES + 1 cycles with out_ready tied high.
- Gaps: idle cycles (in_valid=0) between beats do not advance the counter and do not disturb the accumulator.
- LANES == LEN: every transfer is a last beat.
  - Beat counter width is max(1, clog2(LEN/LANES)).
- Width rule without SAT_EN:
  - Products and the accumulator are truncated to N bits, modulo 2^N.
  - This matches the existing multiplier/adder tree.
- Reset mid-vector or in HOLD: the partial sum is discarded and all state returns to reset values. The next beat starts a new vector.
- Reset has priority over all handshakes in the same cycle.

Optional Feature:
- Macro: SEQ_DOT_PROD_SAT_EN.
- Defined:
  - Products are kept at full 2N bits.
  - The accumulator is 2N+clog2(LEN) bits signed.
  - On the last beat, the final sum is saturated to signed N bits: 0x7FF..F if above, 0x800..0 if below.
- Undefined:
  - Modulo-2^N truncation as described in Behaviour.
  - No wide accumulator is instantiated.

Test Plan (defaults N=32, LEN=16, LANES=4):
- Four beats, all lanes 1 x 1, out_ready=1 -> out_valid one cycle after beat 4, dotprodout=16, in_ready back to 1 on the next cycle.
- Four beats, A lanes = -1 (0xFFFFFFFF), B lanes = 3 -> dotprodout = 0xFFFFFFD0 (-48).
- Complete vector (all lanes 2 x 2), out_ready held low 5 cycles -> out_valid=1, dotprodout=64 stable, in_ready=0; in_valid asserted during the hold is ignored. Release out_ready -> one handshake, then ACCUM.
- Two beats of 5 x 5, then reset pulse, then four beats of 2 x 2 -> dotprodout=64; no residue from the aborted vector.
- Four beats of 1 x 7, each separated by 3 idle cycles with in_valid=0 -> dotprodout=112; counter advances only on transfers.
- All lanes 0x7FFFFFFF x 0x7FFFFFFF:
  - Without SAT_EN -> dotprodout = 16, since each truncated product is 1.
  - With SEQ_DOT_PROD_SAT_EN -> dotprodout = 0x7FFFFFFF.
